// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter that shares one multi-cycle multiplier among NREQ requesters.
// Optional macro MULT_ARB_TIMEOUT_EN adds a WAIT-state watchdog that ends a stalled operation with rsp_err.
module mult_share_arbiter #(
  parameter int WIDTH   = 16,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] a_in,
  input  logic [NREQ*WIDTH-1:0] b_in,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [2*WIDTH-1:0]    rsp_data,
  output logic                  rsp_err,
  output logic                  busy,
  output logic                  mul_start,
  output logic [WIDTH-1:0]      mul_a,
  output logic [WIDTH-1:0]      mul_b,
  input  logic                  mul_done,
  input  logic [2*WIDTH-1:0]    mul_result
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [PW-1:0]      r_ptr;
  logic [PW-1:0]      r_winIdx;
  logic [PW-1:0]      w_winIdx;
  logic [PW-1:0]      w_cand;
  logic               w_found;
  logic               w_load;
  logic               w_capture;
  logic               w_timeout;
  logic               w_expire;
  logic [NREQ-1:0]    r_gnt;
  logic [WIDTH-1:0]   r_mulA;
  logic [WIDTH-1:0]   r_mulB;
  logic [2*WIDTH-1:0] r_rspData;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_paramCheck
    $error("mult_share_arbiter: NREQ must be 2..8 and TIMEOUT at least 1");
  end

  // Search starts just after the last winner, so that winner has the lowest priority.
  always_comb begin
    w_winIdx = '0;
    w_cand   = '0;
    w_found  = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = PW'((int'(r_ptr) + k) % NREQ);
      if (!w_found && req[w_cand]) begin
        w_found  = 1'b1;
        w_winIdx = w_cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_capture = 1'b0;
    w_timeout = 1'b0;
    busy      = (r_state != IDLE);
    mul_start = 1'b0;
    rsp_valid = '0;
    case (r_state)
      IDLE: begin
        if (|req) begin
          w_next = ISSUE;
          w_load = 1'b1;
        end
      end
      ISSUE: begin
        mul_start = 1'b1;
        w_next    = WAIT;
      end
      WAIT: begin
        if (mul_done) begin
          w_next    = RESP;
          w_capture = 1'b1;
        end else if (w_expire) begin
          w_next    = RESP;
          w_timeout = 1'b1;
        end
      end
      RESP: begin
        rsp_valid = r_gnt;
        w_next    = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Operands and grant are latched at arbitration and held until the response leaves.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr     <= PW'(NREQ - 1);
      r_winIdx  <= '0;
      r_gnt     <= '0;
      r_mulA    <= '0;
      r_mulB    <= '0;
      r_rspData <= '0;
    end else begin
      if (w_load) begin
        r_winIdx <= w_winIdx;
        r_gnt    <= NREQ'(1) << w_winIdx;
        r_mulA   <= a_in[w_winIdx*WIDTH +: WIDTH];
        r_mulB   <= b_in[w_winIdx*WIDTH +: WIDTH];
      end
      if (w_capture)      r_rspData <= mul_result;
      else if (w_timeout) r_rspData <= '0;
      if (r_state == RESP) begin
        r_ptr <= r_winIdx;
        r_gnt <= '0;
      end
    end
  end

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_wdCount;
  logic          r_rspErr;

  // Count holds the number of completed WAIT cycles; expiry fires in the TIMEOUT-th one.
  assign w_expire = (r_state == WAIT) && (r_wdCount == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wdCount <= '0;
      r_rspErr  <= 1'b0;
    end else begin
      if (r_state == ISSUE)     r_wdCount <= '0;
      else if (r_state == WAIT) r_wdCount <= r_wdCount + CW'(1);
      if (w_capture)      r_rspErr <= 1'b0;
      else if (w_timeout) r_rspErr <= 1'b1;
    end
  end

  assign rsp_err = r_rspErr;
`else
  assign w_expire = 1'b0;
  assign rsp_err  = 1'b0;
`endif

  assign gnt      = r_gnt;
  assign mul_a    = r_mulA;
  assign mul_b    = r_mulB;
  assign rsp_data = r_rspData;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter: table of directed transactions plus
// hand-written reset-abort, spurious-done and watchdog sequences (MULT_ARB_TIMEOUT_EN aware).
module tb_mult_share_arbiter;

  localparam int WIDTH   = 16;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 8;

  typedef struct {
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] aIn;
    logic [NREQ*WIDTH-1:0] bIn;
    int                    delay;
    int                    expIdx;
    logic [2*WIDTH-1:0]    expData;
  } vec_t;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] a_in;
  logic [NREQ*WIDTH-1:0] b_in;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       rsp_valid;
  logic [2*WIDTH-1:0]    rsp_data;
  logic                  rsp_err;
  logic                  busy;
  logic                  mul_start;
  logic [WIDTH-1:0]      mul_a;
  logic [WIDTH-1:0]      mul_b;
  logic                  mul_done;
  logic [2*WIDTH-1:0]    mul_result;

  logic               modelDone;
  logic [2*WIDTH-1:0] modelResult;
  logic               forceDone;
  logic [2*WIDTH-1:0] forceResult;
  logic               modelEn;
  int                 doneDelay;
  int                 modelA;
  int                 modelB;

  int checks   = 0;
  int failures = 0;

  vec_t vecs[11];
  vec_t vecAbort;
  vec_t vecAfterReset;

  assign mul_done   = modelDone | forceDone;
  assign mul_result = forceDone ? forceResult : modelResult;

  always #5 clk = ~clk;

  mult_share_arbiter #(
    .WIDTH   (WIDTH),
    .NREQ    (NREQ),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .a_in       (a_in),
    .b_in       (b_in),
    .gnt        (gnt),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .mul_start  (mul_start),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_done   (mul_done),
    .mul_result (mul_result)
  );

  // Shared-multiplier model: raises mul_done doneDelay cycles after the start cycle.
  initial begin
    modelDone   = 1'b0;
    modelResult = '0;
    forever begin
      @(negedge clk);
      if (mul_start && modelEn) begin
        modelA = int'(signed'(mul_a));
        modelB = int'(signed'(mul_b));
        repeat (doneDelay) @(negedge clk);
        modelDone   = 1'b1;
        modelResult = 32'(modelA * modelB);
        @(negedge clk);
        modelDone = 1'b0;
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL globalTimeout: simulation did not finish, required completion");
    $fatal(1, "[TB] global time limit reached");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    req       = v.req;
    a_in      = v.aIn;
    b_in      = v.bIn;
    doneDelay = v.delay;
  endtask

  task automatic waitStart(output int n);
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      n++;
      if (mul_start) break;
    end
  endtask

  // Applied during an IDLE cycle; returns at the negedge of the following IDLE cycle.
  task automatic runVector(input vec_t v, input string tag);
    int n;
    logic [NREQ-1:0] expGnt;
    expGnt = NREQ'(1) << v.expIdx;
    applyStimulus(v);
    waitStart(n);
    checkOutput({tag, " startLatency"}, 64'(n), 64'(1));
    checkOutput({tag, " gnt"}, 64'(gnt), 64'(expGnt));
    checkOutput({tag, " mul_a"}, 64'(mul_a), 64'(v.aIn[v.expIdx*WIDTH +: WIDTH]));
    checkOutput({tag, " mul_b"}, 64'(mul_b), 64'(v.bIn[v.expIdx*WIDTH +: WIDTH]));
    @(negedge clk);
    checkOutput({tag, " startPulse"}, 64'({mul_start, busy}), 64'(2'b01));
    n = 1;
    while (rsp_valid == '0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, " respLatency"}, 64'(n), 64'(v.delay + 1));
    checkOutput({tag, " rsp_valid"}, 64'(rsp_valid), 64'(expGnt));
    checkOutput({tag, " rsp_data"}, 64'(rsp_data), 64'(v.expData));
    checkOutput({tag, " rsp_err"}, 64'(rsp_err), 64'(0));
    checkOutput({tag, " gntHeld"}, 64'(gnt), 64'(expGnt));
    @(negedge clk);
    checkOutput({tag, " idleAfter"}, 64'({rsp_valid, gnt, busy}), 64'(0));
  endtask

  initial begin
    int n;
    logic stuckBusy;
    logic sawValid;

    vecs[0]  = '{4'b1111, 64'h0005_0004_0003_0002, 64'hFFD8_001E_FFEC_000A, 3, 0, 32'h0000_0014};
    vecs[1]  = '{4'b1111, 64'h0005_0004_0003_0002, 64'hFFD8_001E_FFEC_000A, 1, 1, 32'hFFFF_FFC4};
    vecs[2]  = '{4'b1111, 64'h0005_0004_0003_0002, 64'hFFD8_001E_FFEC_000A, 2, 2, 32'h0000_0078};
    vecs[3]  = '{4'b1111, 64'h0005_0004_0003_0002, 64'hFFD8_001E_FFEC_000A, 4, 3, 32'hFFFF_FF38};
    vecs[4]  = '{4'b1111, 64'h0005_0004_0003_0002, 64'hFFD8_001E_FFEC_000A, 1, 0, 32'h0000_0014};
    vecs[5]  = '{4'b0001, 64'h0000_0000_0000_0003, 64'h0000_0000_0000_FFF9, 5, 0, 32'hFFFF_FFEB};
    vecs[6]  = '{4'b1001, 64'h7FFF_0000_0000_8000, 64'h8000_0000_0000_8000, 2, 3, 32'hC000_8000};
    vecs[7]  = '{4'b1001, 64'h7FFF_0000_0000_8000, 64'h8000_0000_0000_8000, 1, 0, 32'h4000_0000};
    vecs[8]  = '{4'b0110, 64'h0000_7FFF_FFFF_0000, 64'h0000_7FFF_FFFF_0000, 2, 1, 32'h0000_0001};
    vecs[9]  = '{4'b0110, 64'h0000_7FFF_FFFF_0000, 64'h0000_7FFF_FFFF_0000, 3, 2, 32'h3FFF_0001};
    vecs[10] = '{4'b0010, 64'h0000_0000_0000_0000, 64'h0000_0000_04D2_0000, 1, 1, 32'h0000_0000};
    vecAbort      = '{4'b0001, 64'h0000_0000_0000_0009, 64'h0000_0000_0000_0009, 1, 0, 32'h0000_0051};
    vecAfterReset = '{4'b0100, 64'h0000_FFFB_0000_0000, 64'h0000_0006_0000_0000, 3, 2, 32'hFFFF_FFE2};

    reset       = 1'b1;
    req         = '0;
    a_in        = '0;
    b_in        = '0;
    modelEn     = 1'b1;
    doneDelay   = 1;
    forceDone   = 1'b0;
    forceResult = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset gnt/rsp_valid", 64'({gnt, rsp_valid}), 64'(0));
    checkOutput("reset flags", 64'({rsp_err, busy, mul_start}), 64'(0));
    checkOutput("reset operands", 64'({mul_a, mul_b}), 64'(0));
    checkOutput("reset rsp_data", 64'(rsp_data), 64'(0));
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++) runVector(vecs[i], $sformatf("vec%0d", i));

    // Spurious completion strobe while idle must not change anything.
    req         = '0;
    forceResult = 32'h1234_5678;
    forceDone   = 1'b1;
    @(negedge clk);
    forceDone = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("spurious idle%0d", k), 64'({rsp_valid, gnt, busy}), 64'(0));
    end
    checkOutput("spurious rsp_data", 64'(rsp_data), 64'(vecs[10].expData));

    // Reset in WAIT aborts the operation; the late mul_done is ignored.
    modelEn = 1'b0;
    applyStimulus(vecAbort);
    waitStart(n);
    checkOutput("abort startLatency", 64'(n), 64'(1));
    repeat (2) @(negedge clk);
    checkOutput("abort busyInWait", 64'(busy), 64'(1));
    reset = 1'b1;
    req   = '0;
    @(negedge clk);
    reset       = 1'b0;
    forceResult = 32'hDEAD_BEEF;
    forceDone   = 1'b1;
    @(negedge clk);
    forceDone = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("abort idle%0d", k), 64'({rsp_valid, gnt, busy}), 64'(0));
    end
    checkOutput("abort rsp_data", 64'(rsp_data), 64'(0));
    modelEn = 1'b1;
    runVector(vecAfterReset, "afterReset");

    // Multiplier that never answers.
    modelEn = 1'b0;
    req     = 4'b0010;
    a_in    = 64'h0000_0000_0011_0000;
    b_in    = 64'h0000_0000_0022_0000;
    waitStart(n);
    checkOutput("stall startLatency", 64'(n), 64'(1));
`ifdef MULT_ARB_TIMEOUT_EN
    n = 0;
    while (rsp_valid == '0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("timeout latency", 64'(n), 64'(TIMEOUT + 1));
    checkOutput("timeout rsp_valid", 64'(rsp_valid), 64'(4'b0010));
    checkOutput("timeout rsp_err", 64'(rsp_err), 64'(1));
    checkOutput("timeout rsp_data", 64'(rsp_data), 64'(0));
    req = '0;
    @(negedge clk);
    checkOutput("timeout idleAfter", 64'({rsp_valid, busy}), 64'(0));
`else
    stuckBusy = 1'b1;
    sawValid  = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!busy) stuckBusy = 1'b0;
      if (rsp_valid != '0) sawValid = 1'b1;
    end
    checkOutput("noWatchdog busyHeld", 64'(stuckBusy), 64'(1));
    checkOutput("noWatchdog noResponse", 64'(sawValid), 64'(0));
    reset = 1'b1;
    req   = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("noWatchdog resetRecovers", 64'(busy), 64'(0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_share_arbiter.md
MULT_SHARE_ARBITER -- requirements
Module: mult_share_arbiter

Interface
REQ-001 Parameters SHALL be: WIDTH, 16, operand width; NREQ, 4, requester count (2..8); TIMEOUT, 32, watchdog limit in cycles.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req  input  NREQ  per-requester multiply request, level.
REQ-005 a_in, b_in  input  NREQ*WIDTH each  packed signed operands; slice i belongs to requester i.
REQ-006 gnt  output  NREQ  one-hot grant, registered.
REQ-007 rsp_valid  output  NREQ  one-hot, one-cycle response strobe.
REQ-008 rsp_data  output  2*WIDTH  signed product, shared by all requesters.
REQ-009 rsp_err  output  1  timeout flag, qualified by rsp_valid.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 mul_start  output  1  one-cycle start pulse to the shared multiplier.
REQ-012 mul_a, mul_b  output  WIDTH each  registered multiplier operands.
REQ-013 mul_done  input  1  multiplier completion strobe.
REQ-014 mul_result  input  2*WIDTH  multiplier product; valid while mul_done is high.

Function
REQ-015 FSM SHALL have four states: IDLE, ISSUE, WAIT, RESP.
REQ-016 IDLE with req != 0: choose the winner round-robin, searching from index ptr+1 (mod NREQ); latch its a_in/b_in into mul_a/mul_b; set gnt one-hot; go to ISSUE.
REQ-017 IDLE with req == 0: stay in IDLE; gnt = 0.
REQ-018 ISSUE: mul_start = 1 for exactly this cycle; go to WAIT unconditionally.
REQ-019 WAIT: on mul_done = 1, capture mul_result into rsp_data and go to RESP; otherwise stay in WAIT.
REQ-020 RESP: rsp_valid[winner] = 1 for one cycle; ptr <= winner; gnt cleared; go to IDLE.
REQ-021 mul_a, mul_b and gnt SHALL hold stable from ISSUE through RESP.
REQ-022 rsp_data SHALL hold its last value until the next capture.
REQ-023 Requester i SHALL keep req[i] high and its operands stable until rsp_valid[i].
REQ-024 If req[i] is still high in the cycle after rsp_valid[i], it is a new request and competes normally.
REQ-025 Because ptr points at the last winner, the last winner has the lowest priority in the next arbitration.
REQ-026 mul_done in IDLE, ISSUE or RESP SHALL be ignored.
REQ-027 req changes outside IDLE SHALL be ignored; arbitration occurs only in IDLE.
REQ-028 Latency SHALL be: req sampled at edge t -> mul_start high in cycle t+1 -> rsp_valid in the cycle after the cycle in which mul_done is high.
REQ-029 Minimum back-to-back spacing SHALL be one IDLE cycle between RESP and the next ISSUE.
REQ-030 Width rule: rsp_data is the full 2*WIDTH signed product with no truncation or saturation.

Reset
REQ-031 When reset = 1 at a rising edge: state = IDLE; ptr = NREQ-1 (so requester 0 wins first); gnt, rsp_valid, rsp_err and mul_start = 0; mul_a, mul_b and rsp_data = 0; watchdog count = 0.
REQ-032 Reset in any state SHALL abort the operation in flight with no rsp_valid.
REQ-033 After reset, any mul_done from the aborted operation SHALL be ignored per REQ-026.

Configuration
REQ-034 The macro MULT_ARB_TIMEOUT_EN SHALL compile in a watchdog: a counter cleared on entering WAIT and incremented each WAIT cycle.
REQ-035 With MULT_ARB_TIMEOUT_EN, if the count reaches TIMEOUT without mul_done, the FSM goes to RESP with rsp_err = 1 and rsp_data = 0.
REQ-036 With MULT_ARB_TIMEOUT_EN, if mul_done and expiry coincide, mul_done wins and rsp_err = 0.
REQ-037 Without MULT_ARB_TIMEOUT_EN, no counter logic exists, rsp_err is tied to 0, and WAIT lasts until mul_done.

Verification
REQ-038 Single request: reset, then req = 0001, a = 3, b = -7, model done 5 cycles after start -> gnt = 0001, one mul_start pulse, rsp_valid = 0001 with rsp_data = -21, rsp_err = 0.
REQ-039 Round-robin: req = 1111 held continuously -> grant order 0, 1, 2, 3, 0, with exactly one rsp_valid bit per transaction.
REQ-040 Extremes at WIDTH = 16: a = -32768, b = -32768 -> rsp_data = 0x40000000; a = 32767, b = -32768 -> rsp_data = 0xC0008000.
REQ-041 Reset mid-operation: assert reset in WAIT, then deliver mul_done -> no rsp_valid, busy = 0, and the next req = 0100 is granted normally.
REQ-042 Timeout with MULT_ARB_TIMEOUT_EN, TIMEOUT = 8, mul_done never asserted -> rsp_valid after 8 WAIT cycles with rsp_err = 1 and rsp_data = 0; without the macro, busy stays high indefinitely.
REQ-043 Spurious mul_done in IDLE -> no state change and no rsp_valid.
